// File: rtl/seg7_scan_driver.sv
`default_nettype none
// =====================================================================
// seg7_scan_driver : multiplexed, double-buffered common-anode 7-seg driver
// Revision 1.0
// =====================================================================
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_i,
  input  logic [NUM_DIGITS-1:0]   en_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  output logic [6:0]              SEG,
  output logic                    DP,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic                    frame_tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] c_CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] c_BLANK   = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] c_IDX_MAX = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_act_data, r_pend_data;
  logic [NUM_DIGITS-1:0]   r_act_en, r_pend_en;
  logic [NUM_DIGITS-1:0]   r_act_dp, r_pend_dp;
  logic                    r_pend_valid;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_tick;

  logic                    w_cnt_wrap;
  logic                    w_frame_wrap;
  logic [3:0]              w_sel_nib;
  logic                    w_sel_en;
  logic                    w_sel_dp;
  logic                    w_lit;
  logic [NUM_DIGITS-1:0]   w_an;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign w_cnt_wrap   = (r_cnt == c_CNT_MAX);
  assign w_frame_wrap = w_cnt_wrap && (r_idx == c_IDX_MAX);

  // An idx with no matching digit falls through to the blank defaults.
  always_comb begin
    w_sel_nib = 4'h0;
    w_sel_en  = 1'b0;
    w_sel_dp  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IW'(k)) begin
        w_sel_nib = r_act_data[4*k +: 4];
        w_sel_en  = r_act_en[k];
        w_sel_dp  = r_act_dp[k];
      end
    end
  end

  assign w_lit = (r_cnt >= c_BLANK) && w_sel_en;

  always_comb begin
    w_an = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (w_lit && (r_idx == IW'(k))) w_an[k] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_act_data   <= '0;
      r_act_en     <= '0;
      r_act_dp     <= '0;
      r_pend_data  <= '0;
      r_pend_en    <= '0;
      r_pend_dp    <= '0;
      r_pend_valid <= 1'b0;
      r_seg        <= 7'h7F;
      r_dp         <= 1'b1;
      r_an         <= '1;
      r_tick       <= 1'b0;
    end else begin
      if (w_cnt_wrap) begin
        r_cnt <= '0;
        r_idx <= (r_idx == c_IDX_MAX) ? '0 : r_idx + IW'(1);
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end

      // A load on the wrap cycle lands in pending after the swap reads it.
      if (w_frame_wrap && r_pend_valid) begin
        r_act_data   <= r_pend_data;
        r_act_en     <= r_pend_en;
        r_act_dp     <= r_pend_dp;
        r_pend_valid <= 1'b0;
      end
      if (load) begin
        r_pend_data  <= data_i;
        r_pend_en    <= en_i;
        r_pend_dp    <= dp_i;
        r_pend_valid <= 1'b1;
      end

      r_seg  <= w_lit ? hex7(w_sel_nib) : 7'h7F;
      r_dp   <= w_lit ? ~w_sel_dp : 1'b1;
      r_an   <= w_an;
      r_tick <= (r_cnt == '0) && (r_idx == '0);
    end
  end

  assign SEG        = r_seg;
  assign DP         = r_dp;
  assign AN         = r_an;
  assign frame_tick = r_tick;

endmodule
`default_nettype wire
